// File: rtl/ifetch_queue_if.sv
// Handshake bundle of the instruction-fetch queue: redirect, memory fetch port
// and instruction delivery port. The master side is the queue itself.
interface ifetch_queue_if #(
    parameter int unsigned ADDR_W = 32'd25
);
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack_i;
    logic [63:0]       mem_data_i;
    logic              inst_valid_o;
    logic              inst_ready_i;
    logic [63:0]       inst_o;
    logic [1:0]        inst_len_o;
    logic [ADDR_W-1:0] inst_pc_o;

    modport master (
        input  redirect_i, redirect_pc_i, mem_ack_i, mem_data_i, inst_ready_i,
        output mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_len_o, inst_pc_o
    );

    modport slave (
        output redirect_i, redirect_pc_i, mem_ack_i, mem_data_i, inst_ready_i,
        input  mem_req_o, mem_addr_o, inst_valid_o, inst_o, inst_len_o, inst_pc_o
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: fetches 4 halfwords per memory request into a
// halfword ring and delivers variable-length (16/32/48/64-bit) instructions.
module ifetch_queue #(
    parameter int unsigned        ADDR_W   = 32'd25,
    parameter int unsigned        QUEUE_HW = 32'd8,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    ifetch_queue_if.master   bus
);
    localparam int unsigned PTR_W = $clog2(QUEUE_HW);
    localparam int unsigned CNT_W = PTR_W + 32'd1;
    localparam logic [CNT_W-1:0] FETCH_HW  = CNT_W'(3'd4);
    localparam logic [CNT_W-1:0] REQ_LIMIT = CNT_W'(QUEUE_HW - 32'd4);

    // Length code from the first halfword: 0=16, 1=32, 2=48, 3=64 bits.
    function automatic logic [1:0] decode_len(input logic [15:0] h);
        logic [1:0] len;
        if (h[10:9] != 2'b11) begin
            if ((h[15:11] == 5'd0) && h[7]) len = 2'd1;
            else                            len = 2'd0;
        end else if ((h[15:11] != 5'd0) && (h[8:6] == 3'd0)) begin
            len = 2'd1;
        end else if (h[5]) begin
            len = 2'd2;
        end else begin
            len = 2'd3;
        end
        return len;
    endfunction

    logic [15:0]       ring_r [QUEUE_HW];
    logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [ADDR_W-1:0] pc_r, fetch_pc_r, mem_addr_r;
    logic              req_r, discard_r;

    logic [1:0]        len_s;
    logic [CNT_W-1:0]  len_hw_s;
    logic              valid_s, pop_s, ack_s, push_s, req_next_s, new_req_s, discard_next_s;
    logic [CNT_W-1:0]  count_next_s;
    logic [ADDR_W-1:0] fetch_pc_next_s;
    logic [63:0]       inst_s;

    // Head decode, handshakes and next-state of counters/flags.
    always_comb begin
        len_s    = decode_len(ring_r[rd_ptr_r]);
        len_hw_s = CNT_W'(len_s) + CNT_W'(1'b1);
        valid_s  = (count_r >= len_hw_s);
        pop_s    = valid_s & bus.inst_ready_i;
        ack_s    = req_r & bus.mem_ack_i;
        // Data of a request issued before a redirect must never enter the ring.
        push_s   = ack_s & ~discard_r & ~bus.redirect_i;

        count_next_s    = count_r;
        fetch_pc_next_s = fetch_pc_r;
        if (bus.redirect_i) begin
            count_next_s    = {CNT_W{1'b0}};
            fetch_pc_next_s = bus.redirect_pc_i;
        end else begin
            count_next_s = count_r + (push_s ? FETCH_HW : {CNT_W{1'b0}})
                                   - (pop_s ? len_hw_s : {CNT_W{1'b0}});
            if (push_s) fetch_pc_next_s = fetch_pc_r + ADDR_W'(3'd4);
            else        fetch_pc_next_s = fetch_pc_r;
        end

        if (req_r && !bus.mem_ack_i) begin
            req_next_s = 1'b1;
            new_req_s  = 1'b0;
        end else begin
            req_next_s = ~bus.redirect_i && (count_next_s <= REQ_LIMIT);
            new_req_s  = req_next_s;
        end

        if (bus.redirect_i && req_r && !bus.mem_ack_i) discard_next_s = 1'b1;
        else if (ack_s)                                discard_next_s = 1'b0;
        else                                           discard_next_s = discard_r;
    end

    // Assemble the head instruction across the ring wrap; unused halfwords read 0.
    always_comb begin
        inst_s = 64'd0;
        for (int k = 0; k < 4; k++) begin
            if (k <= int'(len_s)) inst_s[16*k +: 16] = ring_r[rd_ptr_r + PTR_W'(k)];
            else                  inst_s[16*k +: 16] = 16'd0;
        end
    end

    // Queue storage, pointers, PCs and the single-outstanding request state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(QUEUE_HW); i++) ring_r[i] <= 16'd0;
            rd_ptr_r   <= {PTR_W{1'b0}};
            wr_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            pc_r       <= RESET_PC;
            fetch_pc_r <= RESET_PC;
            mem_addr_r <= RESET_PC;
            req_r      <= 1'b0;
            discard_r  <= 1'b0;
        end else begin
            if (push_s) begin
                for (int k = 0; k < 4; k++) ring_r[wr_ptr_r + PTR_W'(k)] <= bus.mem_data_i[16*k +: 16];
            end
            if (bus.redirect_i) begin
                rd_ptr_r <= {PTR_W{1'b0}};
                wr_ptr_r <= {PTR_W{1'b0}};
                pc_r     <= bus.redirect_pc_i;
            end else begin
                rd_ptr_r <= rd_ptr_r + (pop_s ? PTR_W'(len_hw_s) : {PTR_W{1'b0}});
                wr_ptr_r <= wr_ptr_r + (push_s ? PTR_W'(3'd4) : {PTR_W{1'b0}});
                pc_r     <= pc_r + (pop_s ? ADDR_W'(len_hw_s) : {ADDR_W{1'b0}});
            end
            count_r    <= count_next_s;
            fetch_pc_r <= fetch_pc_next_s;
            req_r      <= req_next_s;
            discard_r  <= discard_next_s;
            if (new_req_s) mem_addr_r <= fetch_pc_next_s;
            else           mem_addr_r <= mem_addr_r;
        end
    end

    assign bus.mem_req_o    = req_r;
    assign bus.mem_addr_o   = mem_addr_r;
    assign bus.inst_valid_o = valid_s;
    assign bus.inst_o       = inst_s;
    assign bus.inst_len_o   = len_s;
    assign bus.inst_pc_o    = pc_r;
endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter ADDR_W, default 25, is the halfword-address width of all PC and fetch-address ports.
REQ-002 Parameter QUEUE_HW, default 8, is the prefetch queue depth in halfwords; it shall be a power of two and at least 8.
REQ-003 Parameter RESET_PC, default 0, is the fetch PC loaded at reset.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: redirect_i  input  1  flush request; restart fetching at redirect_pc_i.
REQ-007 Port: redirect_pc_i  input  ADDR_W  new halfword PC.
REQ-008 Port: mem_req_o  output  1  fetch request.
REQ-009 Port: mem_addr_o  output  ADDR_W  halfword address of the fetch.
REQ-010 Port: mem_ack_i  input  1  request accepted; mem_data_i is valid in the same cycle.
REQ-011 Port: mem_data_i  input  64  four halfwords; halfword k occupies bits [16k+15:16k] and is located at mem_addr_o+k.
REQ-012 Port: inst_valid_o  output  1  the head instruction is complete in the queue.
REQ-013 Port: inst_ready_i  input  1  the consumer accepts the instruction.
REQ-014 Port: inst_o  output  64  head instruction, first halfword in bits [15:0]; unused upper halfwords are 0.
REQ-015 Port: inst_len_o  output  2  instruction length: 0=16, 1=32, 2=48, 3=64 bits.
REQ-016 Port: inst_pc_o  output  ADDR_W  halfword PC of the head instruction.

Function
REQ-017 The queue shall be a ring of QUEUE_HW halfwords with read pointer, write pointer and a count ranging 0..QUEUE_HW; both pointers wrap modulo QUEUE_HW.
REQ-018 Length decode on the head halfword h: when h[10:9]!=2'b11, the instruction shall be 32-bit if h[15:11]==0 and h[7]==1 (JR/JARL), else 16-bit.
REQ-019 When h[10:9]==2'b11: the instruction shall be 32-bit if h[15:11]!=0 and h[8:6]==0; otherwise 48-bit if h[5]==1; otherwise 64-bit.
REQ-020 inst_valid_o shall be high exactly when count is at least the decoded length in halfwords (combinational from registered queue state).
REQ-021 Pop: when inst_valid_o and inst_ready_i are both high, advance the read pointer and inst_pc_o by the length in halfwords and decrease count by the same amount.
REQ-022 Fetch: raise mem_req_o when no request is pending, redirect_i is low, and free space (QUEUE_HW-count) is at least 4.
REQ-023 While mem_req_o is high and mem_ack_i is low, mem_req_o and mem_addr_o shall be held stable.
REQ-024 At most one request is outstanding at a time.
REQ-025 On mem_ack_i, write four halfwords at the write pointer, add 4 to count, and add 4 to the fetch address (mod 2^ADDR_W); mem_req_o may rise again in the next cycle.
REQ-026 When a push and a pop occur in the same cycle, count shall change by 4 minus the popped length.
REQ-027 Redirect has priority over push and pop in the same cycle: count:=0, pointers:=0, inst_pc_o and fetch address:=redirect_pc_i; any pop in that cycle is ignored.
REQ-028 Redirect with a request held but not acked: the request continues until acked; its data is discarded (discard flag), and the next request uses redirect_pc_i.
REQ-029 Redirect coinciding with mem_ack_i: the acked data shall be discarded.
REQ-030 A second redirect while the discard flag is set shall update the PCs only; exactly one ack shall be discarded.
REQ-031 Address arithmetic shall wrap modulo 2^ADDR_W without error.

Reset
REQ-032 While reset is high: mem_req_o=0, mem_addr_o=RESET_PC, inst_valid_o=0, inst_o=0, inst_len_o=0, inst_pc_o=RESET_PC, count=0, pointers=0, discard flag=0.
REQ-033 Reset asserted mid-transaction shall abandon the pending request, and the first request after release shall be issued at RESET_PC.

Verification
REQ-034 Bench: reset released, memory acks with data 0x0000_0000_0001_0001 -> request at 0, then two 16-bit instructions at PC 0 and 1; the queue refills at address 4.
REQ-035 Bench: head h=0x0781 (h[10:9]=11, reg2=0, h[5]=0) -> inst_len_o=3, and inst_valid_o stays low until count>=4.
REQ-036 Bench: a 32-bit instruction with reg2=1 and h[8:6]=0 straddling the ring wrap (halfwords 7 and 0) -> inst_o reassembled correctly, inst_pc_o advances by 2.
REQ-037 Bench: redirect_i to 0x100 while mem_req_o is high and unacked -> the ack's data is dropped, the next mem_addr_o is 0x100, and inst_valid_o stays low until that data arrives.
REQ-038 Bench: inst_ready_i held low with QUEUE_HW=8 -> after two acks count=8 and mem_req_o stays low; a single 16-bit pop (count=7) still leaves mem_req_o low.
REQ-039 Bench: reset pulsed while a request is pending -> all outputs take their REQ-032 values immediately, and the first post-reset request is at RESET_PC.
